// File: rtl/sc_lane_collision_pkg.sv
// Shared game-wide definitions for the lane and collision blocks: widths,
// game state codes and the collision FSM state codes.
package sc_lane_collision_pkg;

  localparam int DATAWIDTH_BUS    = 8;
  localparam int DATAWIDTH_ESTADO = 3;
  localparam int DATAWIDTH_LIVES  = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILTER   = 3'd1,
    ST_HIT_REQ  = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_DEAD     = 3'd4
  } lane_state_t;

  typedef enum logic [DATAWIDTH_ESTADO-1:0] {
    ESTADO_START = 3'b000,
    ESTADO_WAIT  = 3'b001,
    ESTADO_PLAY  = 3'b010,
    ESTADO_LOSE  = 3'b011,
    ESTADO_WIN   = 3'b100
  } estado_t;

  function automatic logic [DATAWIDTH_LIVES-1:0] lives_dec_sat(
    input logic [DATAWIDTH_LIVES-1:0] lives
  );
    return (lives == '0) ? '0 : lives - DATAWIDTH_LIVES'(1);
  endfunction

endpackage

// File: rtl/sc_lane_collision_if.sv
// Bus between one lane's collision checker and the main game controller.
// Hit handshake: HIT_OUT rises and stays high until HIT_ACK_IN is sampled
// high on a rising clock edge; HIT_OUT then drops on the following cycle.
// HIT_ACK_IN while HIT_OUT is low has no effect.
interface sc_lane_collision_if;
  import sc_lane_collision_pkg::*;

  logic [DATAWIDTH_BUS-1:0]    SC_LANE_COLLISION_LANE_IN;
  logic [DATAWIDTH_BUS-1:0]    SC_LANE_COLLISION_FROG_COL_IN;
  logic                        SC_LANE_COLLISION_FROG_ON_LANE_IN;
  logic [DATAWIDTH_ESTADO-1:0] SC_LANE_COLLISION_ESTADO_IN;
  logic                        SC_LANE_COLLISION_HIT_ACK_IN;
  logic                        SC_LANE_COLLISION_LIVES_LOAD_IN;
  logic                        SC_LANE_COLLISION_HIT_OUT;
  logic                        SC_LANE_COLLISION_GAMEOVER_OUT;
  logic [DATAWIDTH_LIVES-1:0]  SC_LANE_COLLISION_LIVES_OUT;
  lane_state_t                 state_dbg;

  modport slave (
    input  SC_LANE_COLLISION_LANE_IN, SC_LANE_COLLISION_FROG_COL_IN,
           SC_LANE_COLLISION_FROG_ON_LANE_IN, SC_LANE_COLLISION_ESTADO_IN,
           SC_LANE_COLLISION_HIT_ACK_IN, SC_LANE_COLLISION_LIVES_LOAD_IN,
    output SC_LANE_COLLISION_HIT_OUT, SC_LANE_COLLISION_GAMEOVER_OUT,
           SC_LANE_COLLISION_LIVES_OUT, state_dbg
  );

  modport master (
    output SC_LANE_COLLISION_LANE_IN, SC_LANE_COLLISION_FROG_COL_IN,
           SC_LANE_COLLISION_FROG_ON_LANE_IN, SC_LANE_COLLISION_ESTADO_IN,
           SC_LANE_COLLISION_HIT_ACK_IN, SC_LANE_COLLISION_LIVES_LOAD_IN,
    input  SC_LANE_COLLISION_HIT_OUT, SC_LANE_COLLISION_GAMEOVER_OUT,
           SC_LANE_COLLISION_LIVES_OUT, state_dbg
  );
endinterface

// File: rtl/sc_lane_collision_timer.sv
// Loadable down-counter with a zero flag; stops at zero. Load has priority
// over decrement.
module sc_lane_collision_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_lane_collision.sv
// Lane collision checker: filters frog/vehicle overlap into a held hit request,
// tracks lives and game-over. Optional cooldown via SC_LANE_COLLISION_COOLDOWN_EN.
module sc_lane_collision
  import sc_lane_collision_pkg::*;
#(
  parameter logic [DATAWIDTH_ESTADO-1:0] PLAY_STATE      = ESTADO_PLAY,
  parameter int unsigned                 LIVES_INIT      = 3,
  parameter int unsigned                 HIT_FILTER      = 2,
  parameter int unsigned                 COOLDOWN_CYCLES = 16
) (
  input logic                SC_LANE_COLLISION_CLOCK_50,
  input logic                SC_LANE_COLLISION_RESET,
  sc_lane_collision_if.slave bus
);

  localparam int FW = $clog2(HIT_FILTER + 1);
  localparam logic [DATAWIDTH_LIVES-1:0] LIVES_RELOAD = DATAWIDTH_LIVES'(LIVES_INIT);

  logic                       overlap;
  logic                       active;
  lane_state_t                state_q, state_d;
  logic [FW-1:0]              filt_q, filt_d;
  logic [DATAWIDTH_LIVES-1:0] lives_q, lives_d;
  logic                       hit_entry;

  assign overlap = bus.SC_LANE_COLLISION_FROG_ON_LANE_IN &
                   (|(bus.SC_LANE_COLLISION_LANE_IN & bus.SC_LANE_COLLISION_FROG_COL_IN));
  assign active  = (bus.SC_LANE_COLLISION_ESTADO_IN == PLAY_STATE);

`ifdef SC_LANE_COLLISION_COOLDOWN_EN
  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  logic          cool_load, cool_dec, cool_zero;
  logic [CW-1:0] unused_cool_count;

  sc_lane_collision_timer #(.WIDTH(CW)) u_cooldown (
    .clk        (SC_LANE_COLLISION_CLOCK_50),
    .rst        (SC_LANE_COLLISION_RESET),
    .load       (cool_load),
    .load_value (CW'(COOLDOWN_CYCLES - 1)),
    .dec        (cool_dec),
    .count      (unused_cool_count),
    .zero       (cool_zero)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (COOLDOWN_CYCLES > 0);
`endif

  always_comb begin
    state_d   = state_q;
    filt_d    = filt_q;
    hit_entry = 1'b0;
`ifdef SC_LANE_COLLISION_COOLDOWN_EN
    cool_load = 1'b0;
    cool_dec  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (active && overlap) begin
          if (HIT_FILTER == 1) begin
            state_d   = ST_HIT_REQ;
            filt_d    = '0;
            hit_entry = 1'b1;
          end else begin
            state_d = ST_FILTER;
            filt_d  = FW'(1);
          end
        end
      end
      ST_FILTER: begin
        if (active && overlap) begin
          if ((filt_q + FW'(1)) == FW'(HIT_FILTER)) begin
            state_d   = ST_HIT_REQ;
            filt_d    = '0;
            hit_entry = 1'b1;
          end else begin
            filt_d = filt_q + FW'(1);
          end
        end else begin
          state_d = ST_IDLE;
          filt_d  = '0;
        end
      end
      ST_HIT_REQ: begin
        if (bus.SC_LANE_COLLISION_HIT_ACK_IN) begin
          if (lives_q == '0) begin
            state_d = ST_DEAD;
          end else begin
`ifdef SC_LANE_COLLISION_COOLDOWN_EN
            state_d   = ST_COOLDOWN;
            cool_load = 1'b1;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef SC_LANE_COLLISION_COOLDOWN_EN
      ST_COOLDOWN: begin
        // Overlap is deliberately not looked at while invulnerable.
        if (!active || cool_zero) begin
          state_d = ST_IDLE;
        end else begin
          cool_dec = 1'b1;
        end
      end
`endif
      ST_DEAD: begin
        if (bus.SC_LANE_COLLISION_LIVES_LOAD_IN) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        filt_d  = '0;
      end
    endcase

    // A reload beats a simultaneous hit decrement.
    if (bus.SC_LANE_COLLISION_LIVES_LOAD_IN) begin
      lives_d = LIVES_RELOAD;
    end else if (hit_entry) begin
      lives_d = lives_dec_sat(lives_q);
    end else begin
      lives_d = lives_q;
    end
  end

  always_ff @(posedge SC_LANE_COLLISION_CLOCK_50) begin
    if (SC_LANE_COLLISION_RESET) begin
      state_q <= ST_IDLE;
      filt_q  <= '0;
      lives_q <= LIVES_RELOAD;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      lives_q <= lives_d;
    end
  end

  assign bus.SC_LANE_COLLISION_HIT_OUT      = (state_q == ST_HIT_REQ);
  assign bus.SC_LANE_COLLISION_GAMEOVER_OUT = (state_q == ST_DEAD);
  assign bus.SC_LANE_COLLISION_LIVES_OUT    = lives_q;
  assign bus.state_dbg                      = state_q;

endmodule

// File: tb/tb_sc_lane_collision.sv
// Bench for sc_lane_collision: directed scenarios then random traffic, checked
// cycle by cycle against a behavioural model through an expected queue.
module tb_sc_lane_collision;
  import sc_lane_collision_pkg::*;

  localparam int HF = 2;
  localparam int CD = 16;
  localparam int LI = 3;
  localparam logic [2:0] PLAY = 3'b010;
`ifdef SC_LANE_COLLISION_COOLDOWN_EN
  localparam bit COOL_EN = 1'b1;
`else
  localparam bit COOL_EN = 1'b0;
`endif

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sc_lane_collision_if bus();

  sc_lane_collision #(
    .PLAY_STATE(PLAY), .LIVES_INIT(LI), .HIT_FILTER(HF), .COOLDOWN_CYCLES(CD)
  ) dut (
    .SC_LANE_COLLISION_CLOCK_50 (clk),
    .SC_LANE_COLLISION_RESET    (rst),
    .bus                        (bus)
  );

  // ---- scoreboard ----
  logic [4:0] exp_q[$];  // {hit, gameover, lives}
  int checks = 0;
  int errors = 0;

  // ---- behavioural reference model ----
  int m_run, m_cool, m_lives;
  bit m_hit, m_dead;

  task automatic model(input logic [7:0] lane, col, input logic on,
                       input logic [2:0] est, input logic ack, load, r);
    bit ov, act, entry;
    int lives_pre;
    ov = on && ((lane & col) != 8'h00);
    act = (est == PLAY);
    entry = 1'b0;
    lives_pre = m_lives;
    if (r) begin
      m_run = 0; m_cool = 0; m_hit = 0; m_dead = 0; m_lives = LI;
    end else begin
      if (m_dead) begin
        if (load) m_dead = 0;
      end else if (m_hit) begin
        if (ack) begin
          m_hit = 0;
          if (lives_pre == 0) m_dead = 1;
          else if (COOL_EN) m_cool = CD;
        end
      end else if (m_cool > 0) begin
        m_run = 0;
        if (!act) m_cool = 0;
        else m_cool = m_cool - 1;
      end else if (act && ov) begin
        m_run = m_run + 1;
        if (m_run == HF) begin
          m_hit = 1; m_run = 0; entry = 1'b1;
        end
      end else begin
        m_run = 0;
      end
      if (load) m_lives = LI;
      else if (entry && m_lives > 0) m_lives = m_lives - 1;
    end
  endtask

  // ---- driver ----
  task automatic step(input logic [7:0] lane, col, input logic on,
                      input logic [2:0] est, input logic ack, load, r);
    @(negedge clk);
    bus.SC_LANE_COLLISION_LANE_IN         = lane;
    bus.SC_LANE_COLLISION_FROG_COL_IN     = col;
    bus.SC_LANE_COLLISION_FROG_ON_LANE_IN = on;
    bus.SC_LANE_COLLISION_ESTADO_IN       = est;
    bus.SC_LANE_COLLISION_HIT_ACK_IN      = ack;
    bus.SC_LANE_COLLISION_LIVES_LOAD_IN   = load;
    rst = r;
    model(lane, col, on, est, ack, load, r);
    exp_q.push_back({m_hit, m_dead, 3'(m_lives)});
  endtask

  // frog at column 3, on lane, no reset
  task automatic fstep(input logic [7:0] lane, input logic [2:0] est,
                       input logic ack, load);
    step(lane, 8'b0000_1000, 1'b1, est, ack, load, 1'b0);
  endtask

  task automatic chk(input string name, input logic [7:0] actual, expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---- monitor ----
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hit_out", 8'(bus.SC_LANE_COLLISION_HIT_OUT), 8'(e[4]));
        chk("gameover_out", 8'(bus.SC_LANE_COLLISION_GAMEOVER_OUT), 8'(e[3]));
        chk("lives_out", 8'(bus.SC_LANE_COLLISION_LIVES_OUT), 8'(e[2:0]));
      end
    end
  end

  // ---- stimulus ----
  initial begin
    int drain;
    rst = 1'b1;
    bus.SC_LANE_COLLISION_LANE_IN         = '0;
    bus.SC_LANE_COLLISION_FROG_COL_IN     = '0;
    bus.SC_LANE_COLLISION_FROG_ON_LANE_IN = 1'b0;
    bus.SC_LANE_COLLISION_ESTADO_IN       = '0;
    bus.SC_LANE_COLLISION_HIT_ACK_IN      = 1'b0;
    bus.SC_LANE_COLLISION_LIVES_LOAD_IN   = 1'b0;
    m_run = 0; m_cool = 0; m_hit = 0; m_dead = 0; m_lives = LI;

    repeat (2) step(8'h00, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);

    // basic hit, held until ack
    repeat (5) fstep(8'b0001_1000, PLAY, 1'b0, 1'b0);
    fstep(8'b0001_1000, PLAY, 1'b1, 1'b0);
    repeat (3) fstep(8'b0000_0000, PLAY, 1'b0, 1'b0);

    // glitch: single overlap cycle then clear lane
    fstep(8'b0001_1000, PLAY, 1'b0, 1'b0);
    repeat (4) fstep(8'b0011_0000, PLAY, 1'b0, 1'b0);
    // single-cycle gap restarts filtering
    fstep(8'b0001_1000, PLAY, 1'b0, 1'b0);
    fstep(8'b0011_0000, PLAY, 1'b0, 1'b0);
    repeat (3) fstep(8'b0001_1000, PLAY, 1'b0, 1'b0);
    fstep(8'b0001_1000, PLAY, 1'b1, 1'b0);

    // overlap held through cooldown (or straight re-hit without cooldown)
    repeat (24) fstep(8'b0001_1000, PLAY, 1'b0, 1'b0);

    // exhaust lives with ack held, then keep overlapping while dead
    repeat (60) fstep(8'b0001_1000, PLAY, 1'b1, 1'b0);
    repeat (5) fstep(8'b0001_1000, PLAY, 1'b0, 1'b0);
    fstep(8'b0000_0000, PLAY, 1'b0, 1'b1);
    fstep(8'b0000_0000, PLAY, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("state_after_load", 8'(bus.state_dbg), 8'(ST_IDLE));

    // state gating, then PLAY mid-overlap
    repeat (4) fstep(8'b0001_1000, 3'b001, 1'b0, 1'b0);
    repeat (3) fstep(8'b0001_1000, PLAY, 1'b0, 1'b0);
    // reset while hit is pending
    step(8'b0001_1000, 8'b0000_1000, 1'b1, PLAY, 1'b0, 1'b0, 1'b1);
    repeat (2) fstep(8'b0000_0000, PLAY, 1'b0, 1'b0);
    // load coinciding with a hit entry
    fstep(8'b0001_1000, PLAY, 1'b0, 1'b0);
    fstep(8'b0001_1000, PLAY, 1'b0, 1'b1);
    fstep(8'b0001_1000, PLAY, 1'b1, 1'b0);
    // leaving PLAY during cooldown
    repeat (3) fstep(8'b0001_1000, 3'b011, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] lane, col;
      logic [2:0] est;
      lane = 8'($urandom);
      col  = 8'(1) << $urandom_range(0, 7);
      est  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : PLAY;
      step(lane, col, ($urandom_range(0, 9) != 0), est,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 199) == 0));
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
